// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one external 16-bit asynchronous SRAM between a CPU port and a
// video scanout port. One requester is granted at a time; the SRAM strobes
// are held for WAIT cycles, then a one-cycle RECOVER slot returns the ack
// with the strobes released. CPU writes to non-writable pages are refused
// with a cpu_fault pulse and never reach the SRAM.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cpu_req/we/addr/bsel/wdata    CPU request (level, held until ack/fault)
//   cpu_writable                  writable flag of cpu_addr's page
//   cpu_ack, cpu_fault            one-cycle completion / refusal pulses
//   cpu_rdata                     registered CPU read data
//   vid_req/addr                  video read request (level, held until ack)
//   vid_ack, vid_rdata            video completion pulse, registered data
//   sram_addr                     word address (byte address >> 1)
//   sram_dq_o/dq_oe/dq_i          SRAM data bus out / drive enable / in
//   sram_we_n, sram_oe_n          active-low write / output strobes
//   sram_be_n                     active-low byte enables
module sram_arbiter #(
  parameter int AW   = 22,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [1:0]    cpu_bsel,
  input  logic [15:0]   cpu_wdata,
  input  logic          cpu_writable,
  output logic          cpu_ack,
  output logic          cpu_fault,
  output logic [15:0]   cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_rdata,
  output logic [AW-2:0] sram_addr,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic [1:0]    sram_be_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t     state_r, state_nxt;
  logic [3:0] cnt_r;
  logic       last_vid_r;
  logic       gnt_vid_r;
  logic       gnt_we_r;

  logic       sel_vid_s, sel_cpu_s, fault_s, start_s, cnt_done_s, acc_we_s;
  logic       we_n_nxt, oe_n_nxt, dq_oe_nxt;
  logic       cpu_ack_nxt, vid_ack_nxt, cpu_fault_nxt;

  // Byte-address bit 0 has no meaning on a 16-bit word bus.
  logic       unused_s;
  assign unused_s = cpu_addr[0] ^ vid_addr[0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Arbitration and next-state logic. Under contention the grant goes to
  // whichever port did not win last time, so the two ports alternate.
  always_comb begin
    sel_vid_s = 1'b0;
    sel_cpu_s = 1'b0;
    if (state_r == IDLE) begin
      sel_vid_s = vid_req & (~cpu_req | ~last_vid_r);
      sel_cpu_s = cpu_req & ~sel_vid_s;
    end else begin
      sel_vid_s = 1'b0;
      sel_cpu_s = 1'b0;
    end
    fault_s    = sel_cpu_s & cpu_we & ~cpu_writable;
    start_s    = (sel_vid_s | sel_cpu_s) & ~fault_s;
    cnt_done_s = (state_r == ACCESS) && (cnt_r == 4'd0);

    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (fault_s) begin
          state_nxt = RECOVER;
        end else if (start_s) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_done_s) begin
          state_nxt = RECOVER;
        end else begin
          state_nxt = ACCESS;
        end
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered strobes and pulses.
  // Strobes follow the state being entered, so they are already valid in
  // the first ACCESS cycle and already released in RECOVER.
  always_comb begin
    acc_we_s      = (state_r == IDLE) ? (sel_cpu_s & cpu_we) : gnt_we_r;
    oe_n_nxt      = ~((state_nxt == ACCESS) & ~acc_we_s);
    we_n_nxt      = ~((state_nxt == ACCESS) &  acc_we_s);
    dq_oe_nxt     =  (state_nxt == ACCESS) &  acc_we_s;
    cpu_ack_nxt   = cnt_done_s & ~gnt_vid_r;
    vid_ack_nxt   = cnt_done_s &  gnt_vid_r;
    cpu_fault_nxt = fault_s;
  end

  // Registered strobes and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_fault  <= 1'b0;
    end else begin
      sram_we_n  <= we_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_dq_oe <= dq_oe_nxt;
      cpu_ack    <= cpu_ack_nxt;
      vid_ack    <= vid_ack_nxt;
      cpu_fault  <= cpu_fault_nxt;
    end
  end

  // Grant bookkeeping, address/byte-enable/data latches and wait counter.
  // The latches only move on a real grant, so they stay stable through
  // ACCESS and RECOVER.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr  <= '0;
      sram_be_n  <= 2'b11;
      sram_dq_o  <= 16'h0000;
      gnt_vid_r  <= 1'b0;
      gnt_we_r   <= 1'b0;
      cnt_r      <= 4'd0;
      last_vid_r <= 1'b0;
    end else begin
      if (sel_vid_s | sel_cpu_s) begin
        last_vid_r <= sel_vid_s;
      end
      if (start_s) begin
        sram_addr <= sel_vid_s ? vid_addr[AW-1:1] : cpu_addr[AW-1:1];
        sram_be_n <= (sel_cpu_s & cpu_we) ? ~cpu_bsel : 2'b00;
        if (sel_cpu_s) begin
          sram_dq_o <= cpu_wdata;
        end
        gnt_vid_r <= sel_vid_s;
        gnt_we_r  <= sel_cpu_s & cpu_we;
        cnt_r     <= CNT_INIT;
      end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Read data capture at the edge ending the last ACCESS cycle; each port's
  // register holds until that port's next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata <= 16'h0000;
      vid_rdata <= 16'h0000;
    end else if (cnt_done_s && !gnt_we_r) begin
      if (gnt_vid_r) begin
        vid_rdata <= sram_dq_i;
      end else begin
        cpu_rdata <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_writable;
  logic [21:0] cpu_addr, vid_addr;
  logic [1:0]  cpu_bsel;
  logic [15:0] cpu_wdata, dq_i;
  logic        vid_req;
  logic        cpu_ack, cpu_fault, vid_ack;
  logic [15:0] cpu_rdata, vid_rdata, sram_dq_o;
  logic [20:0] sram_addr;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;
  logic [1:0]  sram_be_n;

  // Extra builds for the WAIT extremes (video-only traffic).
  logic        w1_vid_req, w15_vid_req;
  logic        w1_cpu_ack, w1_cpu_fault, w1_vid_ack, w1_dq_oe, w1_we_n, w1_oe_n;
  logic        w15_cpu_ack, w15_cpu_fault, w15_vid_ack, w15_dq_oe, w15_we_n, w15_oe_n;
  logic [15:0] w1_cpu_rdata, w1_vid_rdata, w1_dq_o;
  logic [15:0] w15_cpu_rdata, w15_vid_rdata, w15_dq_o;
  logic [20:0] w1_addr, w15_addr;
  logic [1:0]  w1_be_n, w15_be_n;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.AW(22), .WAIT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_bsel(cpu_bsel),
    .cpu_wdata(cpu_wdata), .cpu_writable(cpu_writable),
    .cpu_ack(cpu_ack), .cpu_fault(cpu_fault), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_be_n(sram_be_n)
  );

  sram_arbiter #(.AW(22), .WAIT(1)) u_w1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(22'h000000), .cpu_bsel(2'b00),
    .cpu_wdata(16'h0000), .cpu_writable(1'b0),
    .cpu_ack(w1_cpu_ack), .cpu_fault(w1_cpu_fault), .cpu_rdata(w1_cpu_rdata),
    .vid_req(w1_vid_req), .vid_addr(22'h000002), .vid_ack(w1_vid_ack), .vid_rdata(w1_vid_rdata),
    .sram_addr(w1_addr), .sram_dq_o(w1_dq_o), .sram_dq_oe(w1_dq_oe),
    .sram_dq_i(dq_i), .sram_we_n(w1_we_n), .sram_oe_n(w1_oe_n), .sram_be_n(w1_be_n)
  );

  sram_arbiter #(.AW(22), .WAIT(15)) u_w15 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(22'h000000), .cpu_bsel(2'b00),
    .cpu_wdata(16'h0000), .cpu_writable(1'b0),
    .cpu_ack(w15_cpu_ack), .cpu_fault(w15_cpu_fault), .cpu_rdata(w15_cpu_rdata),
    .vid_req(w15_vid_req), .vid_addr(22'h000002), .vid_ack(w15_vid_ack), .vid_rdata(w15_vid_rdata),
    .sram_addr(w15_addr), .sram_dq_o(w15_dq_o), .sram_dq_oe(w15_dq_oe),
    .sram_dq_i(dq_i), .sram_we_n(w15_we_n), .sram_oe_n(w15_oe_n), .sram_be_n(w15_be_n)
  );

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_writable = 1'b0; cpu_addr = 22'h0;
    cpu_bsel = 2'b00; cpu_wdata = 16'h0; vid_req = 1'b0; vid_addr = 22'h0;
    dq_i = 16'h0; w1_vid_req = 1'b0; w15_vid_req = 1'b0;
    tick(); tick();
    checks++; if ({cpu_ack, cpu_fault, vid_ack} !== 3'b000) begin errors++;
      $display("FAIL rst_pulses: got %b expected 000", {cpu_ack, cpu_fault, vid_ack}); end
    checks++; if ({cpu_rdata, vid_rdata} !== 32'h0) begin errors++;
      $display("FAIL rst_rdata: got %h expected 0", {cpu_rdata, vid_rdata}); end
    checks++; if (sram_addr !== 21'h0 || sram_dq_o !== 16'h0) begin errors++;
      $display("FAIL rst_addr_dq: got %h/%h expected 0/0", sram_addr, sram_dq_o); end
    checks++; if ({sram_dq_oe, sram_we_n, sram_oe_n, sram_be_n} !== 5'b01111) begin errors++;
      $display("FAIL rst_strobes: got %b expected 01111", {sram_dq_oe, sram_we_n, sram_oe_n, sram_be_n}); end
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    dq_i = 16'hBEEF; cpu_addr = 22'h001234; cpu_we = 1'b0; cpu_req = 1'b1;
    tick(); // cycle 1
    checks++; if (sram_addr !== 21'h00091A) begin errors++;
      $display("FAIL rd_addr: got %h expected 00091a", sram_addr); end
    checks++; if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_be_n !== 2'b00) begin errors++;
      $display("FAIL rd_c1_strobes: got oe_n=%b we_n=%b be_n=%b expected 0 1 00", sram_oe_n, sram_we_n, sram_be_n); end
    tick(); // cycle 2
    checks++; if (sram_oe_n !== 1'b0 || cpu_ack !== 1'b0) begin errors++;
      $display("FAIL rd_c2: got oe_n=%b ack=%b expected 0 0", sram_oe_n, cpu_ack); end
    tick(); // cycle 3
    checks++; if (cpu_ack !== 1'b1 || sram_oe_n !== 1'b1) begin errors++;
      $display("FAIL rd_c3_ack: got ack=%b oe_n=%b expected 1 1", cpu_ack, sram_oe_n); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++;
      $display("FAIL rd_data: got %h expected beef", cpu_rdata); end
    cpu_req = 1'b0;
    tick(); // cycle 4, idle
    checks++; if (cpu_ack !== 1'b0) begin errors++;
      $display("FAIL rd_c4_ack: got %b expected 0", cpu_ack); end
  endtask

  task automatic test_cpu_write();
    dq_i = 16'h0000; cpu_addr = 22'h000100; cpu_we = 1'b1; cpu_bsel = 2'b10;
    cpu_wdata = 16'hA55A; cpu_writable = 1'b1; cpu_req = 1'b1;
    tick(); // cycle 1
    checks++; if (sram_be_n !== 2'b01 || sram_dq_o !== 16'hA55A) begin errors++;
      $display("FAIL wr_be_dq: got be_n=%b dq=%h expected 01 a55a", sram_be_n, sram_dq_o); end
    checks++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1) begin errors++;
      $display("FAIL wr_c1_strobes: got we_n=%b oe=%b oe_n=%b expected 0 1 1", sram_we_n, sram_dq_oe, sram_oe_n); end
    tick(); // cycle 2
    checks++; if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || cpu_ack !== 1'b0) begin errors++;
      $display("FAIL wr_c2: got we_n=%b oe=%b ack=%b expected 0 1 0", sram_we_n, sram_dq_oe, cpu_ack); end
    tick(); // cycle 3
    checks++; if (cpu_ack !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++;
      $display("FAIL wr_c3: got ack=%b we_n=%b oe=%b expected 1 1 0", cpu_ack, sram_we_n, sram_dq_oe); end
    checks++; if (cpu_rdata !== 16'hBEEF || sram_be_n !== 2'b01) begin errors++;
      $display("FAIL wr_hold: got rdata=%h be_n=%b expected beef 01", cpu_rdata, sram_be_n); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    cpu_addr = 22'h000200; cpu_we = 1'b1; cpu_writable = 1'b0; cpu_req = 1'b1;
    tick(); // cycle 1
    checks++; if (cpu_fault !== 1'b1 || cpu_ack !== 1'b0) begin errors++;
      $display("FAIL flt_c1: got fault=%b ack=%b expected 1 0", cpu_fault, cpu_ack); end
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++;
      $display("FAIL flt_c1_strobes: got we_n=%b oe=%b expected 1 0", sram_we_n, sram_dq_oe); end
    cpu_req = 1'b0;
    vid_addr = 22'h000400; dq_i = 16'h1357; vid_req = 1'b1;
    tick(); // cycle 2, idle: video request is sampled here
    checks++; if (cpu_fault !== 1'b0 || cpu_ack !== 1'b0 || sram_we_n !== 1'b1) begin errors++;
      $display("FAIL flt_c2: got fault=%b ack=%b we_n=%b expected 0 0 1", cpu_fault, cpu_ack, sram_we_n); end
    tick(); // cycle 3: video access started, proving idle in cycle 2
    checks++; if (sram_oe_n !== 1'b0 || sram_addr !== 21'h000200) begin errors++;
      $display("FAIL flt_idle: got oe_n=%b addr=%h expected 0 000200", sram_oe_n, sram_addr); end
    tick(); tick(); // cycle 5: video ack
    checks++; if (vid_ack !== 1'b1 || vid_rdata !== 16'h1357) begin errors++;
      $display("FAIL flt_vid: got ack=%b rdata=%h expected 1 1357", vid_ack, vid_rdata); end
    vid_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    cpu_we = 1'b0; cpu_addr = 22'h000010; vid_addr = 22'h000020; dq_i = 16'hC0DE;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      checks++;
      if (vid_ack !== ((c == 3) || (c == 11)) || cpu_ack !== ((c == 7) || (c == 15))) begin
        errors++;
        $display("FAIL alt_acks cycle %0d: got vid=%b cpu=%b expected vid=%b cpu=%b", c,
                 vid_ack, cpu_ack, (c == 3) || (c == 11), (c == 7) || (c == 15));
      end
      if (c == 1) begin
        checks++; if (sram_addr !== 21'h000010) begin errors++;
          $display("FAIL alt_first_vid: got addr %h expected 000010", sram_addr); end
      end else if (c == 5) begin
        checks++; if (sram_addr !== 21'h000008) begin errors++;
          $display("FAIL alt_then_cpu: got addr %h expected 000008", sram_addr); end
      end else begin
      end
    end
    checks++; if (cpu_rdata !== 16'hC0DE || vid_rdata !== 16'hC0DE) begin errors++;
      $display("FAIL alt_rdata: got %h/%h expected c0de/c0de", cpu_rdata, vid_rdata); end
    cpu_req = 1'b0; vid_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    cpu_addr = 22'h000300; cpu_we = 1'b1; cpu_writable = 1'b1; cpu_bsel = 2'b11;
    cpu_wdata = 16'h1111; cpu_req = 1'b1;
    tick(); // cycle 1
    checks++; if (sram_we_n !== 1'b0) begin errors++;
      $display("FAIL rm_pre: got we_n=%b expected 0", sram_we_n); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_be_n !== 2'b11) begin errors++;
      $display("FAIL rm_async: got we_n=%b oe=%b be_n=%b expected 1 0 11", sram_we_n, sram_dq_oe, sram_be_n); end
    checks++; if (cpu_rdata !== 16'h0 || vid_rdata !== 16'h0) begin errors++;
      $display("FAIL rm_rdata: got %h/%h expected 0/0", cpu_rdata, vid_rdata); end
    cpu_req = 1'b0;
    tick(); tick();
    checks++; if (cpu_ack !== 1'b0 || sram_we_n !== 1'b1) begin errors++;
      $display("FAIL rm_noack: got ack=%b we_n=%b expected 0 1", cpu_ack, sram_we_n); end
    reset_n = 1'b1;
    cpu_we = 1'b0; cpu_addr = 22'h000040; dq_i = 16'h5A5A; cpu_req = 1'b1;
    tick(); // cycle 1
    checks++; if (sram_oe_n !== 1'b0 || sram_addr !== 21'h000020) begin errors++;
      $display("FAIL rm_after: got oe_n=%b addr=%h expected 0 000020", sram_oe_n, sram_addr); end
    tick(); tick(); // cycle 3
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h5A5A) begin errors++;
      $display("FAIL rm_after_ack: got ack=%b rdata=%h expected 1 5a5a", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_builds();
    int first1;
    int first15;
    first1 = 0; first15 = 0;
    dq_i = 16'h2468; w1_vid_req = 1'b1; w15_vid_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (w1_vid_ack === 1'b1 && first1 == 0) begin first1 = c; w1_vid_req = 1'b0; end
      if (w15_vid_ack === 1'b1 && first15 == 0) begin first15 = c; w15_vid_req = 1'b0; end
    end
    w1_vid_req = 1'b0; w15_vid_req = 1'b0;
    checks++; if (first1 != 2) begin errors++;
      $display("FAIL wait1_latency: got ack cycle %0d expected 2", first1); end
    checks++; if (first15 != 16) begin errors++;
      $display("FAIL wait15_latency: got ack cycle %0d expected 16", first15); end
    checks++; if (w1_vid_rdata !== 16'h2468 || w15_vid_rdata !== 16'h2468) begin errors++;
      $display("FAIL wait_rdata: got %h/%h expected 2468/2468", w1_vid_rdata, w15_vid_rdata); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_fault();
    test_alternate();
    test_reset_mid();
    test_wait_builds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 16-bit SRAM between the CPU port and the video scanout port. The CPU port carries addresses that have already been translated by the memory-mapping unit, together with that unit's per-page writable flag. The block grants one requester at a time and sequences the SRAM strobes over a fixed number of wait cycles. It returns read data and a completion pulse, and refuses CPU writes to non-writable pages without touching the SRAM.

## Interface
Parameters:
- AW, 22, physical byte-address width (matches the translated address).
- WAIT, 2, SRAM access cycles per transfer; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  level request; held until cpu_ack or cpu_fault.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  translated byte address.
- cpu_bsel  in  2  byte selects for writes; bit 0 = low byte.
- cpu_wdata  in  16  write data.
- cpu_writable  in  1  writable flag for cpu_addr's page.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_fault  out  1  one-cycle pulse: write refused.
- cpu_rdata  out  16  registered read data.
- vid_req  in  1  level read request; held until vid_ack.
- vid_addr  in  AW  byte address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  16  registered read data.
- sram_addr  out  AW-1  word address = granted addr[AW-1:1].
- sram_dq_o  out  16  write data.
- sram_dq_oe  out  1  data bus drive enable.
- sram_dq_i  in  16  read data.
- sram_we_n, sram_oe_n  out  1 each  active-low strobes.
- sram_be_n  out  2  active-low byte enables.

## Operation
- States: IDLE, ACCESS, RECOVER. A wait counter runs in ACCESS. A `last_vid` flag records the previous grant.
- Arbitration in IDLE:
  - Only vid_req high: grant video.
  - Only cpu_req high: grant CPU.
  - Both high: grant CPU if last_vid = 1, otherwise grant video. The two ports therefore alternate under contention.
- CPU write with cpu_writable = 0: no SRAM cycle. The next cycle is RECOVER with cpu_fault = 1 and cpu_ack = 0. last_vid is cleared.
- On grant:
  - Latch sram_addr.
  - Latch sram_be_n: ~cpu_bsel for a CPU write, 2'b00 otherwise.
  - Latch sram_dq_o.
  - Enter ACCESS with the counter at WAIT-1.
- ACCESS:
  - Read: sram_oe_n = 0.
  - Write: sram_we_n = 0 and sram_dq_oe = 1.
  - The counter decrements each cycle. At 0, read data is captured into the granted port's rdata and the state becomes RECOVER.
- RECOVER:
  - All strobes are inactive and sram_dq_oe = 0.
  - The granted port's ack = 1 (or cpu_fault = 1 for a refused write).
  - Next state is IDLE.
- Requesters must drop their req on the edge that samples ack/fault. A req still high in IDLE is a new request.
- rdata registers hold their value until the next read on the same port.

## Timing
- Reset values:
  - State IDLE; last_vid = 0.
  - All acks and cpu_fault = 0.
  - cpu_rdata = vid_rdata = 0.
  - sram_addr = 0, sram_dq_o = 0, sram_dq_oe = 0.
  - sram_we_n = sram_oe_n = 1; sram_be_n = 2'b11.
- Reset mid-access: strobes go inactive immediately (asynchronous), no ack is issued, and rdata is cleared.
- Latency, with request sampled in IDLE at cycle 0:
  - Cycles 1..WAIT: ACCESS.
  - Cycle WAIT+1: RECOVER with ack.
  - Cycle WAIT+2: IDLE, so back-to-back transfers take WAIT+2 cycles each.
- Fault latency: pulse in cycle 1, IDLE in cycle 2.
- sram_addr, sram_be_n and sram_dq_o stay stable from cycle 1 through RECOVER. sram_we_n rises before the address changes.
- sram_dq_i is sampled at the clock edge ending the last ACCESS cycle.
- All outputs are registered.

## Test plan
- CPU read, addr 22'h001234, SRAM returns 16'hBEEF, WAIT = 2 -> sram_addr = 21'h00091A, sram_oe_n low in cycles 1–2, cpu_ack in cycle 3, cpu_rdata = 16'hBEEF.
- CPU byte write, bsel 2'b10, wdata 16'hA55A, writable = 1 -> sram_be_n = 2'b01, sram_we_n low for 2 cycles, sram_dq_oe high, cpu_ack in cycle 3.
- CPU write with cpu_writable = 0 -> sram_we_n never low, cpu_fault = 1 in cycle 1, no cpu_ack, back in IDLE in cycle 2.
- vid_req and cpu_req both held continuously after reset -> grants alternate video, CPU, video, CPU; each ack is spaced 4 cycles apart (WAIT = 2).
- reset_n asserted in the middle of ACCESS on a write -> sram_we_n = 1 and sram_dq_oe = 0 immediately, no ack; after release the first request is served normally.
- WAIT = 1 and WAIT = 15 builds with a single video read -> vid_ack arrives in cycle 2 and in cycle 16 respectively.
